// File: rtl/serial_frame_rx_if.sv
// Output stream of the serial frame receiver: one received payload plus its
// parity status, handed to a consumer with a valid/ready handshake.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              parity_err;

    // Receiver side drives the payload, consumer side drives ready
    modport master (
        output data,
        output valid,
        output parity_err,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  parity_err,
        output ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 1, DATA_W payload bits LSB first, optional
// even-parity bit, stop bit 0, idle line 0. Completed frames land in a single
// holding register offered to the consumer over a valid/ready handshake.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  si,
    serial_frame_rx_if.master     rx,
    output logic                  framing_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_pend_q, perr_pend_d;
    logic              perr_q, perr_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    // Next-state logic: frame sequencing, holding register and handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        perr_pend_d = perr_pend_q;
        perr_d      = perr_q;
        valid_d     = valid_q;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;

        if (valid_q && rx.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (si) begin
                    state_d     = DATA;
                    cnt_d       = '0;
                    perr_pend_d = 1'b0;
                end
            end
            DATA: begin
                shift_d = {si, shift_q[DATA_W-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                perr_pend_d = (^shift_q) ^ si;
                state_d     = STOP;
            end
            STOP: begin
                state_d = IDLE;
                if (si) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || rx.ready) begin
                    data_d  = shift_q;
                    perr_d  = perr_pend_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; clear wins over everything, including a partial frame
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            perr_pend_q <= perr_pend_d;
            perr_q      <= perr_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx.data       = data_q;
    assign rx.valid      = valid_q;
    assign rx.parity_err = perr_q;
    assign framing_err   = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx with default parameters. A
// frame-level reference model tracks what the holding register should contain.
module tb_serial_frame_rx;
    localparam int DW = 8;
    localparam int P  = 1;
    localparam int FL = DW + 2 + P;

    logic clk;
    logic clear;
    logic si;
    logic framing_err;
    logic overrun;
    logic busy;

    serial_frame_rx_if #(.DATA_W(DW)) rx_if ();

    serial_frame_rx #(.DATA_W(DW), .PARITY_EN(P)) dut (
        .clk         (clk),
        .clear       (clear),
        .si          (si),
        .rx          (rx_if),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_perr;
    logic          m_ferr;
    logic          m_ovr;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [FL-1:0] build_frame(input logic [DW-1:0] d,
                                                  input logic pbit,
                                                  input logic stop);
        return {stop, pbit, d, 1'b1};
    endfunction

    // Drive one serial bit and advance the reference model across that edge
    task automatic step(input logic b, input logic rdy, input bit good,
                        input bit bad, input logic [DW-1:0] fd, input logic fpe);
        si          = b;
        rx_if.ready = rdy;
        m_ferr      = 1'b0;
        m_ovr       = 1'b0;
        if (good) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = fd;
                m_perr  = fpe;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (bad) m_ferr = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                              input logic stop, input logic rdy_body,
                              input logic rdy_stop);
        logic [FL-1:0] f;
        f = build_frame(d, pbit, stop);
        for (int i = 0; i < FL; i++) begin
            step(f[i], (i == FL - 1) ? rdy_stop : rdy_body,
                 (i == FL - 1) && !stop, (i == FL - 1) && stop, d, (^d) ^ pbit);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic test_reset();
        clear       = 1'b1;
        si          = 1'b1;
        rx_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        si    = 1'b0;
        model_reset();
        n_checks++;
        if (rx_if.valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0", rx_if.valid);
        end
        n_checks++;
        if (rx_if.data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 00", rx_if.data);
        end
        n_checks++;
        if ({rx_if.parity_err, framing_err, overrun, busy} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {rx_if.parity_err, framing_err, overrun, busy});
        end
    endtask

    task automatic test_basic(input logic pbit, input logic exp_perr);
        logic [FL-1:0] f;
        f = build_frame(8'hA5, pbit, 1'b0);
        for (int i = 0; i < FL; i++) begin
            step(f[i], 1'b1, i == FL - 1, 1'b0, 8'hA5, exp_perr);
            if (i < FL - 1) begin
                n_checks++;
                if (rx_if.valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL basic_early cycle %0d: got valid=%b busy=%b expected valid=0 busy=1",
                             i, rx_if.valid, busy);
                end
            end
        end
        n_checks++;
        if (rx_if.valid !== 1'b1 || rx_if.data !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL basic_done: got valid=%b data=%h expected valid=1 data=a5",
                     rx_if.valid, rx_if.data);
        end
        n_checks++;
        if (rx_if.parity_err !== exp_perr) begin
            n_fail++;
            $display("[TB] FAIL basic_parity: got %b expected %b", rx_if.parity_err, exp_perr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_busy_after_stop: got %b expected 0", busy);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (rx_if.valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_consumed: got valid=%b expected 0", rx_if.valid);
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, ^8'h3C, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (framing_err !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL framing_pulse: got ferr=%b ovr=%b expected ferr=1 ovr=0",
                     framing_err, overrun);
        end
        n_checks++;
        if (rx_if.valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL framing_state: got valid=%b busy=%b expected 0 0",
                     rx_if.valid, busy);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (framing_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL framing_one_cycle: got ferr=%b busy=%b expected 0 0",
                     framing_err, busy);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, ^8'h11, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (rx_if.valid !== 1'b1 || rx_if.data !== 8'h11) begin
            n_fail++;
            $display("[TB] FAIL overrun_first: got valid=%b data=%h expected 1 11",
                     rx_if.valid, rx_if.data);
        end
        send_frame(8'h22, ^8'h22, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b1 || framing_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_pulse: got ovr=%b ferr=%b expected 1 0",
                     overrun, framing_err);
        end
        n_checks++;
        if (rx_if.data !== 8'h11 || rx_if.valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overrun_hold: got valid=%b data=%h expected 1 11",
                     rx_if.valid, rx_if.data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_one_cycle: got %b expected 0", overrun);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (rx_if.valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_drain: got valid=%b expected 0", rx_if.valid);
        end
    endtask

    task automatic test_ready_at_completion();
        send_frame(8'h11, ^8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, ^8'h22, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (rx_if.valid !== 1'b1 || rx_if.data !== 8'h22 || overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL replace_on_ready: got valid=%b data=%h ovr=%b expected 1 22 0",
                     rx_if.valid, rx_if.data, overrun);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (rx_if.valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL replace_drain: got valid=%b expected 0", rx_if.valid);
        end
    endtask

    task automatic test_clear_mid_frame();
        logic [FL-1:0] f;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        f = build_frame(8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(f[i], 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        clear = 1'b1;
        si    = f[5];
        @(posedge clk);
        #1;
        clear = 1'b0;
        si    = 1'b0;
        model_reset();
        n_checks++;
        if ({rx_if.valid, rx_if.parity_err, framing_err, overrun, busy} !== 5'b00000) begin
            n_fail++;
            $display("[TB] FAIL clear_flags: got %b expected 00000",
                     {rx_if.valid, rx_if.parity_err, framing_err, overrun, busy});
        end
        n_checks++;
        if (rx_if.data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL clear_data: got %h expected 00", rx_if.data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (framing_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_no_pulse: got ferr=%b ovr=%b busy=%b expected 0 0 0",
                     framing_err, overrun, busy);
        end
        send_frame(8'h5A, ^8'h5A, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (rx_if.valid !== 1'b1 || rx_if.data !== 8'h5A || rx_if.parity_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_next_frame: got valid=%b data=%h perr=%b expected 1 5a 0",
                     rx_if.valid, rx_if.data, rx_if.parity_err);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Random frames, gaps, stop bits and ready, every cycle checked against the model
    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic          pbit;
        logic          stop;
        logic [FL-1:0] f;
        logic          rdy;
        int            gap;
        for (int n = 0; n < 60; n++) begin
            d    = DW'($urandom);
            pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            stop = ($urandom_range(0, 7) == 0);
            gap  = $urandom_range(0, 2);
            f    = build_frame(d, pbit, stop);
            for (int g = 0; g < gap; g++) begin
                rdy = 1'($urandom);
                step(1'b0, rdy, 1'b0, 1'b0, '0, 1'b0);
                n_checks++;
                if (rx_if.valid !== m_valid || framing_err !== 1'b0 || overrun !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_gap frame %0d: got valid=%b ferr=%b ovr=%b expected %b 0 0",
                             n, rx_if.valid, framing_err, overrun, m_valid);
                end
            end
            for (int i = 0; i < FL; i++) begin
                rdy = 1'($urandom);
                step(f[i], rdy, (i == FL - 1) && !stop, (i == FL - 1) && stop,
                     d, (^d) ^ pbit);
                n_checks++;
                if (rx_if.valid !== m_valid || framing_err !== m_ferr || overrun !== m_ovr) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_flags frame %0d bit %0d: got valid=%b ferr=%b ovr=%b expected %b %b %b",
                             n, i, rx_if.valid, framing_err, overrun, m_valid, m_ferr, m_ovr);
                end
                if (m_valid) begin
                    n_checks++;
                    if (rx_if.data !== m_data || rx_if.parity_err !== m_perr) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_data frame %0d bit %0d: got data=%h perr=%b expected %h %b",
                                 n, i, rx_if.data, rx_if.parity_err, m_data, m_perr);
                    end
                end
            end
        end
    endtask

    // Scenario sequence
    initial begin
        clear       = 1'b1;
        si          = 1'b0;
        rx_if.ready = 1'b0;
        model_reset();
        test_reset();
        test_basic(1'b0, 1'b0);
        test_basic(1'b1, 1'b1);
        test_framing();
        test_overrun();
        test_ready_at_completion();
        test_clear_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of payload bits per frame (2..16).
REQ-002 Parameter PARITY_EN, default 1, 1 = frame carries an even-parity bit, 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 si  input  1  serial bit stream, one bit per clock (driven by the SISO shift register serial output so).
REQ-006 ready  input  1  consumer accepts data when ready and valid are both high.
REQ-007 data  output  DATA_W  received payload, stable while valid is high.
REQ-008 valid  output  1  data holds an unconsumed frame.
REQ-009 parity_err  output  1  parity of the frame currently in data failed; qualified by valid.
REQ-010 framing_err  output  1  one-cycle pulse: stop bit was not 0, frame discarded.
REQ-011 overrun  output  1  one-cycle pulse: good frame completed while holding register full, new frame dropped.
REQ-012 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 Frame format SHALL be: start bit 1, DATA_W data bits first-received = LSB, parity bit (only if PARITY_EN), stop bit 0; line idles at 0.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: si=1 SHALL move to DATA with bit counter = 0; si=0 SHALL stay IDLE.
REQ-016 DATA: each cycle SHALL shift si into shift register MSB (right shift), increment counter; after DATA_W bits, go to PARITY if PARITY_EN else STOP.
REQ-017 PARITY: SHALL sample si and compute even parity over data bits plus parity bit; result latched as pending error flag; go to STOP.
REQ-018 STOP: si=0 SHALL complete the frame; si=1 SHALL pulse framing_err for one cycle and discard the frame; either way go to IDLE.
REQ-019 A stop bit of 1 SHALL NOT be treated as a new start bit; next start is sampled earliest the cycle after STOP.
REQ-020 On completion with valid=0, or valid=1 and ready=1 in the same cycle, data, parity_err SHALL load and valid SHALL be 1 the next cycle (no overrun).
REQ-021 On completion with valid=1 and ready=0, old data SHALL be kept unchanged and overrun SHALL pulse one cycle.
REQ-022 valid SHALL clear on the cycle after ready=1 with valid=1 and no simultaneous completion.
REQ-023 Latency: start bit sampled cycle 0; valid SHALL rise at cycle DATA_W+2+PARITY_EN (cycle 11 for defaults).
REQ-024 Back-to-back frames (start bit in cycle immediately after stop) SHALL be received without loss.
REQ-025 data and parity_err SHALL not change while valid=1 except via REQ-020.
REQ-026 framing_err and overrun SHALL never be high in the same cycle.

Reset
REQ-027 clear=1 SHALL, at the next posedge, set FSM to IDLE, counter 0, shift register 0, data 0, valid 0, parity_err 0, framing_err 0, overrun 0, busy 0.
REQ-028 clear SHALL take priority over every other input, including mid-frame; a partial frame SHALL be discarded without any error pulse.
REQ-029 After clear deasserts, the first si=1 sampled SHALL be treated as a start bit.

Verification
REQ-030 Defaults, ready=1: si = 1, 1,0,1,0,0,1,0,1, 0, 0 -> data=0xA5, valid=1 at cycle 11 for one cycle, parity_err=0.
REQ-031 Same frame with parity bit 1 -> data=0xA5, valid=1, parity_err=1.
REQ-032 Stop bit 1 after 0x3C frame -> framing_err pulse one cycle, valid stays 0, FSM IDLE next cycle.
REQ-033 ready=0, frames 0x11 then 0x22 back-to-back -> data=0x11 held, overrun pulses once at second completion; ready=1 then valid drops.
REQ-034 ready pulsed high exactly at completion of 0x22 while 0x11 held -> data=0x22, valid stays 1, overrun=0.
REQ-035 clear=1 during data bit 4 of a frame -> all outputs 0 next cycle, no error pulses; subsequent frame 0x5A received correctly.
